// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with a 2-bit saturating BHT, one-cycle registered flush
// and saturating branch / misprediction counters.
module branch_resolve_unit #(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [XLEN-1:0]  if_pc,
    output logic             if_pred_taken,
    input  logic             ex_valid,
    input  logic             ex_stall,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_jalr,
    input  logic [2:0]       ex_funct3,
    input  logic [XLEN-1:0]  ex_rs1,
    input  logic [XLEN-1:0]  ex_rs2,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    output logic             redirect,
    output logic [1:0]       pc_src,
    output logic             flush_q,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       r_bht [BHT_ENTRIES];
    logic             r_flush_q;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_act;
    logic             w_taken;
    logic             w_train;
    logic             w_redirect;
    logic [1:0]       w_pc_src;
    logic [IDX_W-1:0] w_if_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic             w_unused;

    assign w_if_idx = if_pc[IDX_W+1:2];
    assign w_ex_idx = ex_pc[IDX_W+1:2];
    assign w_unused = ^{if_pc, ex_pc};

    // Anything in EX while the flush pulse is high is wrong-path and ignored.
    assign w_act   = ex_valid & ~ex_stall & ~r_flush_q;
    assign w_train = w_act & ex_branch & ~ex_jump;

    always_comb begin
        w_taken = 1'b0;
        case (ex_funct3)
            3'b000:  w_taken = (ex_rs1 == ex_rs2);
            3'b001:  w_taken = (ex_rs1 != ex_rs2);
            3'b100:  w_taken = ($signed(ex_rs1) <  $signed(ex_rs2));
            3'b101:  w_taken = ($signed(ex_rs1) >= $signed(ex_rs2));
            3'b110:  w_taken = (ex_rs1 <  ex_rs2);
            3'b111:  w_taken = (ex_rs1 >= ex_rs2);
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_redirect = 1'b0;
        w_pc_src   = 2'b00;
        if (w_act) begin
            if (ex_jump) begin
                w_redirect = 1'b1;
                w_pc_src   = ex_jalr ? 2'b10 : 2'b01;
            end else if (ex_branch) begin
                if (w_taken && !ex_pred_taken) begin
                    w_redirect = 1'b1;
                    w_pc_src   = 2'b01;
                end else if (!w_taken && ex_pred_taken) begin
                    w_redirect = 1'b1;
                    w_pc_src   = 2'b11;
                end
            end
        end
    end

    // Each entry owns its own register so every entry can reset to weak-NT.
    generate
        for (genvar gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_bht[gi] <= 2'b01;
                end else if (w_train && (w_ex_idx == IDX_W'(gi))) begin
                    if (w_taken && r_bht[gi] != 2'b11)
                        r_bht[gi] <= r_bht[gi] + 2'b01;
                    else if (!w_taken && r_bht[gi] != 2'b00)
                        r_bht[gi] <= r_bht[gi] - 2'b01;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flush_q     <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            r_flush_q <= w_redirect;
            if (w_train && r_branch_cnt != {CNT_W{1'b1}})
                r_branch_cnt <= r_branch_cnt + 1'b1;
            if (w_redirect && r_mispred_cnt != {CNT_W{1'b1}})
                r_mispred_cnt <= r_mispred_cnt + 1'b1;
        end
    end

    assign if_pred_taken = r_bht[w_if_idx][1];
    assign redirect      = w_redirect;
    assign pc_src        = w_pc_src;
    assign flush_q       = r_flush_q;
    assign branch_cnt    = r_branch_cnt;
    assign mispred_cnt   = r_mispred_cnt;
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch/jump resolution unit with a 2-bit saturating branch history table (BHT).
- **Fetch stage:** supplies a taken/not-taken prediction per PC.
- **Execute stage:** evaluates all six RV32I branch conditions on full-width operands, detects mispredictions and drives the PC-select code.
- **Sequential state:** trains the BHT, issues a registered one-cycle flush and maintains saturating performance counters.

## Interface
Parameters:
- XLEN, 32, operand width for branch comparisons.
- BHT_ENTRIES, 16, predictor table depth; power of two, ≥2; IDX_W = log2(BHT_ENTRIES).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- if_pc  in  XLEN  fetch PC used for BHT lookup.
- if_pred_taken  out  1  prediction for if_pc.
- ex_valid  in  1  instruction in EX is valid.
- ex_stall  in  1  EX is held this cycle.
- ex_branch  in  1  conditional branch in EX.
- ex_jump  in  1  JAL or JALR in EX.
- ex_jalr  in  1  with ex_jump: 1 = JALR, 0 = JAL.
- ex_funct3  in  3  branch condition code.
- ex_rs1, ex_rs2  in  XLEN  comparison operands.
- ex_pc  in  XLEN  PC of the EX instruction (BHT update index).
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction.
- redirect  out  1  fetch must be redirected this cycle.
- pc_src  out  2  next-PC select; meaningful only when redirect = 1.
  - 00 = no redirect.
  - 01 = ex_pc + imm.
  - 10 = JALR target.
  - 11 = ex_pc + 4 recovery.
- flush_q  out  1  registered one-cycle pulse that squashes wrong-path IF/ID.
- branch_cnt  out  CNT_W  resolved conditional branches.
- mispred_cnt  out  CNT_W  mispredicted conditional branches plus JAL/JALR redirects.

## Operation
**Lookup and prediction**
- Index: idx(pc) = pc[IDX_W+1:2].
- BHT entry encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- if_pred_taken = BHT[idx(if_pc)][1].

**Effective EX valid**
- act = ex_valid & ~ex_stall & ~flush_q.
- While flush_q = 1, the EX instruction is wrong-path: it is ignored completely (no redirect, no update, no count).

**Branch condition (taken)**
- 000 BEQ: rs1 == rs2.
- 001 BNE: rs1 != rs2.
- 100 BLT: signed rs1 < rs2.
- 101 BGE: signed rs1 ≥ rs2.
- 110 BLTU: unsigned rs1 < rs2.
- 111 BGEU: unsigned rs1 ≥ rs2.
- 010 and 011 evaluate as not-taken.
- Comparisons use full XLEN.

**Redirect and pc_src, when act = 1**
- JAL: redirect = 1, pc_src = 01.
- JALR: redirect = 1, pc_src = 10.
- Branch, taken and predicted not-taken: redirect = 1, pc_src = 01.
- Branch, not-taken and predicted taken: redirect = 1, pc_src = 11.
- Branch with correct prediction: redirect = 0, pc_src = 00.
- ex_jump takes priority if ex_branch and ex_jump are both set.
- act = 0 or neither branch nor jump: redirect = 0, pc_src = 00.

**BHT training**
- Only when act & ex_branch & ~ex_jump.
- Entry idx(ex_pc) increments if taken, decrements if not-taken.
- Saturates at 11 and 00.
- Jumps never update the table.

**Counters**
- branch_cnt increments on every training event.
- mispred_cnt increments whenever redirect = 1.
- Both saturate at all-ones; they never wrap.

**Reset**
- All BHT entries → 01.
- flush_q → 0; branch_cnt → 0; mispred_cnt → 0.
- if_pred_taken reads 0 after reset.
- Reset mid-operation discards any pending update or flush at that edge.

## Timing
- if_pred_taken: combinational from registered BHT, same cycle as if_pc.
- redirect and pc_src: combinational, same cycle as the EX instruction; zero latency.
- BHT write, counter increments and flush_q assertion all take effect at the next rising edge.
- flush_q is high for exactly one cycle after each redirect. Back-to-back redirects cannot occur, because the following cycle is squashed.
- Same-cycle lookup and update of the same index: lookup returns the old value (read-before-write). The new value is visible the following cycle.
- ex_stall = 1: no redirect, no update, no count. flush_q still clears on schedule and is not extended by the stall.
- rst has priority over all updates at the same edge.

## Test plan
- **Reset:** assert rst 1 cycle → all outputs 0; if_pred_taken = 0 for every index; counters 0.
- **BEQ with Z:** rs1 = rs2 = 5, pred 0, ex_pc = 0x40 → redirect = 1, pc_src = 01, flush_q = 1 next cycle. BHT[0] = 10, so if_pc = 0x40 predicts taken; mispred_cnt = 1.
- **Signed vs unsigned:** BLT rs1 = 0xFFFFFFFF, rs2 = 1 → taken. BLTU with the same operands → not-taken. With pred = 1 the BLTU gives pc_src = 11.
- **Saturation:** four consecutive taken branches to one index → entry 11; one not-taken → 10, prediction still taken. Other indices stay at 01.
- **Squash shadow:** JALR → redirect, pc_src = 10. A valid branch presented the next cycle (flush_q = 1) → no redirect, no BHT or counter change.
- **Edge cases:** counter saturation at CNT_W = 2 (stays at 3). Stall during a branch → no effect. Same-index lookup and update in one cycle → old value returned.
